// File: rtl/key_event_arbiter.sv
// key_event_arbiter: turns debounced key levels into press/auto-repeat events
// shared on one valid/ready channel with round-robin arbitration.
module key_event_arbiter #(
    parameter int N_KEYS       = 5,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    localparam int IDW = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDW-1:0]    evt_id,
    output logic              evt_repeat,
    output logic [N_KEYS-1:0] pending
);
    localparam int CMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(CMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q, lim;
    logic [IDW-1:0]    trk_q, low, sel, cand, rr_q, evt_id_q;
    logic [N_KEYS-1:0] key_prev_q, pend_q, pend_d, rep_q, rep_d, rise, tick, grant;
    logic              evt_valid_q, evt_repeat_q, tick_en, found, free;

    always_comb begin
        rise = key_level & ~key_prev_q;
        low = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) if (rise[i]) low = IDW'(i);
        lim = (state_q == DELAY) ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1);
        // a fresh rise restarts the timer, so it suppresses any tick that cycle
        tick_en = state_q != IDLE && ~|rise && key_level[trk_q] && cnt_q == lim;
        tick = tick_en ? (N_KEYS'(1) << trk_q) : '0;
        free = ~evt_valid_q | evt_ready;
        found = 1'b0;
        sel = '0;
        cand = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            cand = IDW'((int'(rr_q) + k) % N_KEYS);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                sel = cand;
            end
        end
        grant = (free && found) ? (N_KEYS'(1) << sel) : '0;
        pend_d = (pend_q & ~grant) | rise | tick;
        rep_d = rep_q;
        // press outranks repeat; a repeat only sets the type on a slot that ends up fresh
        for (int i = 0; i < N_KEYS; i++)
            rep_d[i] = rise[i] ? 1'b0 : tick[i] ? (~(pend_q[i] & ~grant[i]) | rep_q[i]) : rep_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            trk_q        <= '0;
            key_prev_q   <= '0;
            pend_q       <= '0;
            rep_q        <= '0;
            rr_q         <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_repeat_q <= 1'b0;
        end else begin
            key_prev_q <= key_level;
            pend_q     <= pend_d;
            rep_q      <= rep_d;
            if (|rise) begin
                state_q <= DELAY;
                trk_q   <= low;
                cnt_q   <= '0;
            end else if (state_q != IDLE) begin
                if (!key_level[trk_q]) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == lim) begin
                    state_q <= REPEAT;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (free) begin
                evt_valid_q <= found;
                if (found) begin
                    evt_id_q     <= sel;
                    evt_repeat_q <= rep_q[sel];
                    rr_q         <= sel;
                end
            end
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign pending    = pend_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed scenarios plus randomized run against a
// cycle-level reference model built from the event/repeat/arbitration rules.
module tb_key_event_arbiter;
    localparam int N = 5;
    localparam int D = 10;
    localparam int R = 4;

    logic         clk, rst_n, rdy, ev, erp;
    logic [N-1:0] kl, pend;
    logic [2:0]   eid;

    int checks = 0;
    int failures = 0;
    int q_off[$];
    int q_id[$];
    logic q_rp[$];
    int exp_off[6] = '{1, 11, 15, 19, 23, 27};

    logic [N-1:0] mpend, mrep, mkprev;
    logic mv, mrp, act;
    int mid, mrr, trk, age;

    key_event_arbiter #(.N_KEYS(N), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .clk(clk), .rst_n(rst_n), .key_level(kl), .evt_valid(ev), .evt_ready(rdy),
        .evt_id(eid), .evt_repeat(erp), .pending(pend)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mpend = '0; mrep = '0; mkprev = '0;
        mv = 0; mrp = 0; act = 0;
        mid = 0; mrr = 0; trk = 0; age = 0;
    endtask

    // One clock of the reference behaviour, using the inputs the DUT just sampled.
    task automatic model_step();
        logic [N-1:0] rise, tck;
        int low, sel, j;
        low = -1;
        tck = '0;
        for (int i = 0; i < N; i++) begin
            rise[i] = kl[i] && !mkprev[i];
            if (rise[i] && low < 0) low = i;
        end
        if (act && low < 0 && kl[trk]) begin
            j = age + 1;
            if (j == D || (j > D && (j - D) % R == 0)) tck[trk] = 1;
        end
        if (low >= 0) begin
            act = 1; trk = low; age = 0;
        end else if (act) begin
            if (!kl[trk]) act = 0;
            else age++;
        end
        if (!mv || rdy) begin
            sel = -1;
            for (int k = 1; k <= N; k++)
                if (sel < 0 && mpend[(mrr + k) % N]) sel = (mrr + k) % N;
            if (sel >= 0) begin
                mv = 1; mid = sel; mrp = mrep[sel]; mrr = sel; mpend[sel] = 0;
            end else mv = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                mpend[i] = 1; mrep[i] = 0;
            end else if (tck[i] && !mpend[i]) begin
                mpend[i] = 1; mrep[i] = 1;
            end
        end
        mkprev = kl;
    endtask

    task automatic test_reset();
        rst_n = 0; kl = '0; rdy = 1;
        repeat (3) cyc();
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ev); end
        checks++; if (eid !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", eid); end
        checks++; if (erp !== 1'b0) begin failures++; $display("FAIL reset_repeat got=%b exp=0", erp); end
        checks++; if (pend !== 5'b0) begin failures++; $display("FAIL reset_pending got=%b exp=00000", pend); end
        rst_n = 1;
        repeat (2) cyc();
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", ev); end
    endtask

    task automatic test_single_press();
        int n = 0;
        kl = 5'b00100;
        cyc();
        checks++; if (pend !== 5'b00100) begin failures++; $display("FAIL single_pending got=%b exp=00100", pend); end
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", ev); end
        kl = '0;
        cyc();
        checks++; if (ev !== 1'b1 || eid !== 3'd2 || erp !== 1'b0)
            begin failures++; $display("FAIL single_event got=v%b id%0d r%b exp=v1 id2 r0", ev, eid, erp); end
        checks++; if (pend !== 5'b0) begin failures++; $display("FAIL single_cleared got=%b exp=00000", pend); end
        cyc();
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL single_one_cycle got=%b exp=0", ev); end
        repeat (15) begin cyc(); if (ev) n++; end
        checks++; if (n != 0) begin failures++; $display("FAIL single_extra got=%0d exp=0", n); end
    endtask

    task automatic test_hold_repeat();
        q_off.delete(); q_id.delete(); q_rp.delete();
        rdy = 1; kl = 5'b00001;
        for (int c = 0; c < 35; c++) begin
            cyc();
            if (ev) begin q_off.push_back(c); q_id.push_back(int'(eid)); q_rp.push_back(erp); end
            if (c == 29) kl = '0;
        end
        checks++; if (q_off.size() != 6) begin failures++; $display("FAIL hold_count got=%0d exp=6", q_off.size()); end
        for (int i = 0; i < 6 && i < q_off.size(); i++) begin
            checks++; if (q_off[i] != exp_off[i]) begin failures++; $display("FAIL hold_time[%0d] got=%0d exp=%0d", i, q_off[i], exp_off[i]); end
            checks++; if (q_id[i] != 0) begin failures++; $display("FAIL hold_id[%0d] got=%0d exp=0", i, q_id[i]); end
            checks++; if (q_rp[i] !== (i > 0)) begin failures++; $display("FAIL hold_type[%0d] got=%b exp=%b", i, q_rp[i], i > 0); end
        end
    endtask

    task automatic test_stall_rr();
        q_id.delete();
        rdy = 0; kl = 5'b11010;
        cyc();
        checks++; if (pend !== 5'b11010) begin failures++; $display("FAIL stall_pending got=%b exp=11010", pend); end
        kl = '0;
        cyc();
        checks++; if (ev !== 1'b1 || eid !== 3'd1) begin failures++; $display("FAIL stall_first got=v%b id%0d exp=v1 id1", ev, eid); end
        checks++; if (pend !== 5'b11000) begin failures++; $display("FAIL stall_rest got=%b exp=11000", pend); end
        for (int c = 0; c < 4; c++) begin
            cyc();
            checks++; if (ev !== 1'b1 || eid !== 3'd1 || erp !== 1'b0)
                begin failures++; $display("FAIL stall_hold[%0d] got=v%b id%0d r%b exp=v1 id1 r0", c, ev, eid, erp); end
        end
        rdy = 1;
        for (int c = 0; c < 6; c++) begin
            if (ev) q_id.push_back(int'(eid));
            cyc();
        end
        checks++; if (q_id.size() != 3) begin failures++; $display("FAIL stall_count got=%0d exp=3", q_id.size()); end
        if (q_id.size() == 3) begin
            checks++; if (q_id[0] != 1 || q_id[1] != 3 || q_id[2] != 4)
                begin failures++; $display("FAIL stall_order got=%0d,%0d,%0d exp=1,3,4", q_id[0], q_id[1], q_id[2]); end
        end
    endtask

    task automatic test_rr_fair();
        q_id.delete();
        rdy = 1;
        for (int c = 0; c < 24; c++) begin
            kl = (c % 2 == 0) ? 5'b00011 : 5'b00000;
            cyc();
            if (ev) q_id.push_back(int'(eid));
        end
        kl = '0;
        repeat (4) cyc();
        checks++; if (q_id.size() < 8) begin failures++; $display("FAIL rr_count got=%0d exp>=8", q_id.size()); end
        for (int i = 0; i < 8 && i < q_id.size(); i++) begin
            checks++; if (q_id[i] != i % 2) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, q_id[i], i % 2); end
        end
    endtask

    task automatic test_retarget();
        int n3 = 0;
        q_off.delete(); q_id.delete(); q_rp.delete();
        rdy = 1; kl = 5'b01000;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (ev && erp && eid == 3'd3) n3++;
        end
        checks++; if (n3 != 3) begin failures++; $display("FAIL retarget_key3_repeats got=%0d exp=3", n3); end
        kl = 5'b01010;
        for (int c = 0; c < 35; c++) begin
            cyc();
            if (ev) begin q_off.push_back(c); q_id.push_back(int'(eid)); q_rp.push_back(erp); end
            if (c == 29) kl = '0;
        end
        checks++; if (q_off.size() != 6) begin failures++; $display("FAIL retarget_count got=%0d exp=6", q_off.size()); end
        for (int i = 0; i < 6 && i < q_off.size(); i++) begin
            checks++; if (q_off[i] != exp_off[i] || q_id[i] != 1 || q_rp[i] !== (i > 0))
                begin failures++; $display("FAIL retarget_evt[%0d] got=t%0d id%0d r%b exp=t%0d id1 r%b", i, q_off[i], q_id[i], q_rp[i], exp_off[i], i > 0); end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        int lid = -1;
        logic lrp = 1'bx;
        rdy = 0; kl = 5'b01000;
        cyc();
        kl = '0;
        cyc();
        kl = 5'b10110;
        cyc();
        checks++; if (pend !== 5'b10110 || ev !== 1'b1 || eid !== 3'd3)
            begin failures++; $display("FAIL areset_setup got=p%b v%b id%0d exp=p10110 v1 id3", pend, ev, eid); end
        kl = 5'b10000;
        #2 rst_n = 0;
        #1;
        checks++; if (ev !== 1'b0 || eid !== 3'd0 || erp !== 1'b0 || pend !== 5'b0)
            begin failures++; $display("FAIL areset_clear got=v%b id%0d r%b p%b exp=v0 id0 r0 p00000", ev, eid, erp, pend); end
        cyc();
        rst_n = 1; rdy = 1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (ev) begin n++; lid = int'(eid); lrp = erp; end
            if (c == 4) kl = '0;
        end
        checks++; if (n != 1 || lid != 4 || lrp !== 1'b0)
            begin failures++; $display("FAIL areset_press got=n%0d id%0d r%b exp=n1 id4 r0", n, lid, lrp); end
    endtask

    task automatic test_random();
        rst_n = 0; kl = '0; rdy = 0;
        model_reset();
        cyc();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) kl[i] = ~kl[i];
            rdy = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            model_step();
            #1;
            checks++;
            if (ev !== mv || pend !== mpend || (mv && (int'(eid) != mid || erp !== mrp)))
                begin failures++; $display("FAIL random[%0d] got=v%b id%0d r%b p%b exp=v%b id%0d r%b p%b", c, ev, eid, erp, pend, mv, mid, mrp, mpend); end
        end
        kl = '0;
    endtask

    initial begin
        rst_n = 0; kl = '0; rdy = 1;
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_stall_rr();
        test_rr_fair();
        test_retarget();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
